// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add MULT/MULTU and restoring DIV/DIVU
// on operand magnitudes, with sign fix-up and HI/LO result registers.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_accept;
  logic   w_fix_wr;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_mb;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_hi_out;
  logic [WIDTH-1:0] r_lo_out;
  logic             r_dbz;

  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic                    w_sgn;
  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [WIDTH:0]          w_madd;
  logic [WIDTH:0]          w_shift;
  logic [WIDTH-1:0]        w_sub;
  logic                    w_qbit;
  logic [2*WIDTH-1:0]      w_prod;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? ('0 - v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? ('0 - v) : v;
  endfunction

  // Two's-complement negate of MIN yields MIN, i.e. the unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic neg);
    return f_neg(v, neg);
  endfunction

  always_comb begin
    w_a_s   = a_i;
    w_b_s   = b_i;
    w_sgn   = ~op_i[0];
    w_a_neg = w_sgn && (w_a_s < 0);
    w_b_neg = w_sgn && (w_b_s < 0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // DONE accepts a new start just like IDLE, giving one operation per WIDTH+2 cycles.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_next = S_IDLE;
        if (start_i && !flush_i) begin
          w_next   = S_CALC;
          w_accept = 1'b1;
        end
      end
      S_CALC: begin
        if (flush_i)               w_next = S_IDLE;
        else if (r_cnt == CNT_ONE) w_next = S_FIX;
      end
      S_FIX:   w_next = flush_i ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (r_state != S_IDLE);
    done_o        = (r_state == S_DONE);
    w_fix_wr      = (r_state == S_FIX) && !flush_i;
    hi_o          = r_hi_out;
    lo_o          = r_lo_out;
    div_by_zero_o = r_dbz;
  end

  // Iteration datapath: one shift-add or one restoring-divide step per CALC cycle.
  always_comb begin
    w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mb} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_qbit  = (w_shift >= {1'b0, r_mb});
    w_sub   = w_shift[WIDTH-1:0] - r_mb;
    w_prod  = f_neg2({r_hi, r_lo}, r_neg_q);
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_op    <= op_i;
      r_a     <= a_i;
      r_mb    <= f_mag(b_i, w_b_neg);
      r_lo    <= f_mag(a_i, w_a_neg);
      r_hi    <= '0;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end else if (r_state == S_CALC) begin
      if (r_op[1]) begin
        r_hi <= w_qbit ? w_sub : w_shift[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], w_qbit};
      end else begin
        r_hi <= w_madd[WIDTH:1];
        r_lo <= {w_madd[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  // Counter and architectural HI/LO; results land on the FIX->DONE edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_hi_out <= '0;
      r_lo_out <= '0;
      r_dbz    <= 1'b0;
    end else begin
      if (w_accept)                 r_cnt <= CNT_LOAD;
      else if (r_state == S_CALC)   r_cnt <= r_cnt - CNT_ONE;
      if (w_fix_wr) begin
        if (!r_op[1]) begin
          {r_hi_out, r_lo_out} <= w_prod;
          r_dbz                <= 1'b0;
        end else if (r_mb == '0) begin
          r_hi_out <= r_a;
          r_lo_out <= '1;
          r_dbz    <= 1'b1;
        end else begin
          r_hi_out <= f_neg(r_hi, r_neg_r);
          r_lo_out <= f_neg(r_lo, r_neg_q);
          r_dbz    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: table of multiply/divide vectors plus a behavioural model,
// a scoreboard queue popped on done_o, and hand sequences for handshake and abort cases.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         flush_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         div_by_zero_o;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  vec_t         scb[$];
  vec_t         tbl[9];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  logic         last_dbz = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .op_i          (op_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .flush_i       (flush_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: still running at 500us, expected finish well before");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dbz = dbz;
    return v;
  endfunction

  function automatic vec_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sbv, q, r;
    logic [63:0]        p;
    logic               dbz;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    dbz = 1'b0;
    p   = '0;
    case (op)
      2'd0: p = sa * sbv;
      2'd1: p = {32'h0, a} * {32'h0, b};
      2'd2: begin
        if (b == '0) begin
          p = {a, 32'hFFFF_FFFF}; dbz = 1'b1;
        end else begin
          q = sa / sbv; r = sa % sbv;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == '0) begin
          p = {a, 32'hFFFF_FFFF}; dbz = 1'b1;
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
    return mk(op, a, b, p[63:32], p[31:0], dbz);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy_o && k < 100) begin
      tick();
      k++;
    end
    chk("wait_idle busy", busy_o, 0);
  endtask

  // Counts edges after the accepting edge until done_o; optionally pulses a stray start at E5.
  task automatic wait_done(output int n, input bit poke);
    n = 0;
    do begin
      if (poke && n == 4) begin
        start_i = 1'b1; op_i = 2'd1; a_i = 32'hDEAD_BEEF; b_i = 32'h0000_1234;
      end
      if (poke && n == 5) start_i = 1'b0;
      tick();
      n++;
    end while (!done_o && n < 60);
  endtask

  task automatic check_result(input string nm);
    vec_t e;
    if (scb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: done_o with empty scoreboard, expected a queued result", nm);
    end else begin
      e = scb.pop_front();
      chk({nm, " hi"}, hi_o, e.hi);
      chk({nm, " lo"}, lo_o, e.lo);
      chk({nm, " dbz"}, div_by_zero_o, e.dbz);
      last_hi = e.hi; last_lo = e.lo; last_dbz = e.dbz;
    end
  endtask

  task automatic run_op(input vec_t v, input bit poke, input string nm);
    int n;
    wait_idle();
    start_i = 1'b1; op_i = v.op; a_i = v.a; b_i = v.b;
    scb.push_back(v);
    tick();
    start_i = 1'b0; op_i = 2'($urandom_range(0, 3)); a_i = $urandom; b_i = $urandom;
    chk({nm, " busy_after_accept"}, busy_o, 1);
    wait_done(n, poke);
    chk({nm, " latency"}, n, 33);
    check_result(nm);
    tick();
    chk({nm, " done_width"}, done_o, 0);
    chk({nm, " busy_after_done"}, busy_o, 0);
  endtask

  initial begin
    int   n;
    int   dcount;
    vec_t va, vb;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    chk("reset busy", busy_o, 0);
    chk("reset done", done_o, 0);
    chk("reset hi", hi_o, 0);
    chk("reset lo", lo_o, 0);
    chk("reset dbz", div_by_zero_o, 0);

    tbl[0] = mk(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    tbl[1] = mk(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    tbl[2] = mk(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    tbl[3] = mk(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    tbl[4] = mk(2'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0);
    tbl[5] = mk(2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    tbl[6] = mk(2'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
    tbl[7] = mk(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    tbl[8] = mk(2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 9; i++) run_op(tbl[i], (i == 3), $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3)); ra = $urandom; rb = $urandom;
      if (i == 1) rb = '0;
      if (i == 2) rb = 32'($urandom_range(1, 15));
      run_op(model(rop, ra, rb), 1'b0, $sformatf("rnd%0d", i));
    end

    // start held high through DONE is taken at E34 with the operands present then
    va = model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    vb = model(2'd3, 32'd100, 32'd7);
    wait_idle();
    start_i = 1'b1; op_i = va.op; a_i = va.a; b_i = va.b;
    scb.push_back(va);
    tick();
    op_i = vb.op; a_i = vb.a; b_i = vb.b;
    wait_done(n, 1'b0);
    chk("held latency_a", n, 33);
    check_result("held a");
    scb.push_back(vb);
    tick();
    start_i = 1'b0; a_i = $urandom; b_i = $urandom;
    chk("held accept busy", busy_o, 1);
    chk("held accept done", done_o, 0);
    wait_done(n, 1'b0);
    chk("held latency_b", n, 33);
    check_result("held b");
    tick();
    chk("held busy_after_done", busy_o, 0);

    // flush sampled at E11
    wait_idle();
    start_i = 1'b1; op_i = 2'd1; a_i = 32'h0000_1234; b_i = 32'h0000_5678;
    tick();
    start_i = 1'b0;
    repeat (10) tick();
    chk("flush busy_before", busy_o, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush busy_after", busy_o, 0);
    dcount = 0;
    repeat (40) begin
      if (done_o) dcount++;
      tick();
    end
    chk("flush no_done", dcount, 0);
    chk("flush hi_hold", hi_o, last_hi);
    chk("flush lo_hold", lo_o, last_lo);
    chk("flush dbz_hold", div_by_zero_o, last_dbz);

    // reset sampled at E20
    wait_idle();
    start_i = 1'b1; op_i = 2'd2; a_i = 32'hFFFF_FF00; b_i = 32'h0000_0003;
    tick();
    start_i = 1'b0;
    repeat (19) tick();
    chk("rst busy_before", busy_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst hi", hi_o, 0);
    chk("rst lo", lo_o, 0);
    chk("rst dbz", div_by_zero_o, 0);
    last_hi = '0; last_lo = '0; last_dbz = 1'b0;

    // flush and start together in IDLE: nothing is accepted
    wait_idle();
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'd1; a_i = 32'd3; b_i = 32'd5;
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start busy", busy_o, 0);
    dcount = 0;
    repeat (40) begin
      if (done_o) dcount++;
      tick();
    end
    chk("flush_start no_done", dcount, 0);
    chk("flush_start lo_hold", lo_o, last_lo);

    run_op(model(2'd2, 32'hFFFF_FF9C, 32'd7), 1'b0, "recover");
    chk("scoreboard empty", scb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
